// File: rtl/adder_serial_pkg.sv
// adder_serial_pkg: shared FSM states, nibble size and saturation constants for the serial adder
package adder_serial_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int NIBBLE = 4;

    // Most-positive ({0,1..1}) or most-negative ({1,0..0}) value for a signed width up to 64 bits
    function automatic logic [63:0] sat_value(input int width, input logic negative);
        sat_value = negative ? (64'd1 << (width - 1)) : ((64'd1 << (width - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/adder_cla_4bit.sv
// adder_cla_4bit: 4-bit carry-lookahead slice with group P/G and signed-overflow outputs
module adder_cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       ovfl,
    output logic       prop_group,
    output logic       gen_group
);

    logic [3:0] p, g;
    logic [4:0] c;

    // Lookahead carries computed directly from generate/propagate terms
    always_comb begin
        p          = a ^ b;
        g          = a & b;
        c[0]       = cin;
        c[1]       = g[0] | (p[0] & cin);
        c[2]       = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3]       = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gen_group  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        prop_group = &p;
        c[4]       = gen_group | (prop_group & cin);
        sum        = p ^ c[3:0];
        cout       = c[4];
        ovfl       = c[3] ^ c[4];
    end

endmodule

// File: rtl/adder_nibble_serial.sv
// adder_nibble_serial: saturating add/subtract computed one nibble per cycle through a shared CLA slice
module adder_nibble_serial
    import adder_serial_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             zero,
    output logic             neg,
    output logic             ovfl
);

    localparam int              NNIB     = WIDTH / NIBBLE;
    localparam int              KW       = $clog2(NNIB);
    localparam logic [KW-1:0]   K_LAST   = KW'(NNIB - 1);
    localparam logic [WIDTH-1:0] MOST_POS = WIDTH'(sat_value(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(sat_value(WIDTH, 1'b1));

    state_e            state_q;
    logic [KW-1:0]     k_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, shadow_q, sum_q;
    logic              zero_q, neg_q, ovfl_q, busy_q, done_q;
    logic [NIBBLE-1:0] a_nib, b_nib, s_nib;
    logic              slice_cout, slice_ovfl;
    logic [WIDTH-1:0]  wrap_d, sum_d;

    // Select the active nibble and form the final (optionally clamped) result for the last edge
    always_comb begin
        a_nib  = a_q[k_q*NIBBLE +: NIBBLE];
        b_nib  = b_q[k_q*NIBBLE +: NIBBLE];
        wrap_d = {s_nib, shadow_q[WIDTH-NIBBLE-1:0]};
        sum_d  = (SATURATE && slice_ovfl) ? (a_q[WIDTH-1] ? MOST_NEG : MOST_POS) : wrap_d;
    end

    adder_cla_4bit u_slice (
        .a          (a_nib),
        .b          (b_nib),
        .cin        (carry_q),
        .sum        (s_nib),
        .cout       (slice_cout),
        .ovfl       (slice_ovfl),
        .prop_group (),
        .gen_group  ()
    );

    // Control FSM, nibble counter, carry chain and result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovfl_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                shadow_q[k_q*NIBBLE +: NIBBLE] <= s_nib;
                carry_q <= slice_cout;
                k_q     <= k_q + 1'b1;
                if (k_q == K_LAST) begin
                    sum_q   <= sum_d;
                    zero_q  <= ~|sum_d;
                    neg_q   <= sum_d[WIDTH-1];
                    ovfl_q  <= slice_ovfl;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else if (start) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                carry_q <= sub;
                k_q     <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovfl = ovfl_q;

endmodule

// File: tb/tb_adder_nibble_serial.sv
// tb_adder_nibble_serial: directed vectors with an arithmetic reference model checked every cycle
module tb_adder_nibble_serial;

    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [15:0] a, b;
    logic        busy, done, zero, neg, ovfl;
    logic [15:0] sum;
    logic        busy_w, done_w, zero_w, neg_w, ovfl_w;
    logic [15:0] sum_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_nibble_serial #(.WIDTH(16), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .zero(zero), .neg(neg), .ovfl(ovfl)
    );

    adder_nibble_serial #(.WIDTH(16), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy_w), .done(done_w), .sum(sum_w), .zero(zero_w), .neg(neg_w), .ovfl(ovfl_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole-word signed arithmetic, result published WIDTH/4 edges after acceptance
    bit          armed = 1'b0;
    int          rem = 0;
    logic        e_busy, e_done, e_zero, e_neg, e_ovfl, e_zero_w, e_neg_w;
    logic [15:0] e_sum, e_sum_w, p_sat, p_wrap;
    logic        p_ov;

    always @(posedge clk) begin
        if (rst) begin
            rem = 0; armed = 1'b1;
            e_busy = 0; e_done = 0; e_sum = 0; e_sum_w = 0;
            e_zero = 0; e_neg = 0; e_ovfl = 0; e_zero_w = 0; e_neg_w = 0;
        end else begin
            e_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    e_done = 1; e_ovfl = p_ov;
                    e_sum = p_sat; e_zero = (p_sat == 0); e_neg = p_sat[15];
                    e_sum_w = p_wrap; e_zero_w = (p_wrap == 0); e_neg_w = p_wrap[15];
                end
            end else if (start) begin
                int r;
                r = sub ? $signed(a) - $signed(b) : $signed(a) + $signed(b);
                p_ov = (r > 32767) || (r < -32768);
                p_wrap = r[15:0];
                p_sat = p_ov ? ((r > 0) ? 16'h7FFF : 16'h8000) : p_wrap;
                rem = 4;
            end
            e_busy = (rem > 0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("sum", sum, e_sum);
            chk("zero", zero, e_zero);
            chk("neg", neg, e_neg);
            chk("ovfl", ovfl, e_ovfl);
            chk("w_busy", busy_w, e_busy);
            chk("w_done", done_w, e_done);
            chk("w_sum", sum_w, e_sum_w);
            chk("w_zero", zero_w, e_zero_w);
            chk("w_neg", neg_w, e_neg_w);
            chk("w_ovfl", ovfl_w, e_ovfl);
        end
    end

    // Issue one operation from a negedge and return on the negedge where done is seen
    task automatic op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input bit inject);
        int lat;
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 2) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", lat, 5);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_sum", sum, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {zero, neg, ovfl}, 3'b000);

        op(16'h1234, 16'h1111, 1'b0, 1'b0);
        chk("add_sum", sum, 16'h2345);
        chk("add_flags", {zero, neg, ovfl}, 3'b000);

        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("psat_sum", sum, 16'h7FFF);
        chk("psat_flags", {neg, ovfl}, 2'b01);
        chk("pwrap_sum", sum_w, 16'h8000);
        chk("pwrap_flags", {neg_w, ovfl_w}, 2'b11);

        op(16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("nsat_sum", sum, 16'h8000);
        chk("nsat_flags", {neg, ovfl}, 2'b11);
        chk("nwrap_sum", sum_w, 16'h7FFF);

        op(16'h0005, 16'h0005, 1'b1, 1'b0);
        chk("zero_sum", sum, 16'h0000);
        chk("zero_flags", {zero, neg, ovfl}, 3'b100);

        op(16'h0003, 16'h0004, 1'b0, 1'b1);
        chk("ignore_sum", sum, 16'h0007);

        op(16'h00F0, 16'h0010, 1'b0, 1'b0);
        chk("b2b_sum", sum, 16'h0100);

        a = 16'h1111; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_sum", sum, 16'h0000);
        chk("mrst_ctl", {busy, done}, 2'b00);
        chk("mrst_flags", {zero, neg, ovfl}, 3'b000);

        rst = 1'b1; start = 1'b1; a = 16'h0009; b = 16'h0009;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_wins_busy", busy, 1'b0);

        op(16'h0001, 16'h0001, 1'b0, 1'b0);
        chk("post_rst_sum", sum, 16'h0002);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_nibble_serial.md
# adder_nibble_serial

Multi-cycle saturating add/subtract unit that reuses one 4-bit CLA adder slice, processing one nibble per cycle from LSB to MSB with a registered carry. It sits downstream of the 4-bit CLA slice and upstream of the ALU result mux and flag register. Area-constrained configurations use it in place of a full-width CLA tree. A start/done handshake drives it, and it produces the result value plus Z/N/V flags.

## Interface
- WIDTH, 16: operand width. Must be a multiple of 4 and at least 8.
- SATURATE, 1: 1 clamps the result on signed overflow; 0 returns the wrapped result.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a−b. Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result and flags valid.
- sum  out  WIDTH  result. Held until the next accepted start.
- zero  out  1  sum == 0, after saturation.
- neg  out  1  sum[WIDTH-1], after saturation.
- ovfl  out  1  signed overflow occurred, before saturation.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1; nibble index k runs 0..WIDTH/4−1.
  - DONE: done=1 for one cycle.
- IDLE, start=1 → RUN. On the same edge:
  - latch a;
  - latch b_eff = sub ? ~b : b;
  - carry ← sub;
  - k ← 0.
- RUN, each edge:
  - The slice adds a_reg[4k+3:4k], b_eff[4k+3:4k] and carry.
  - The nibble result is written to sum_reg[4k+3:4k].
  - carry ← slice cout; k ← k+1.
- RUN, final nibble edge (k = WIDTH/4−1):
  - ovfl ← slice ovfl (carry-in to MSB XOR carry-out of MSB).
  - If SATURATE=1 and overflow: sum ← a_reg[MSB] ? {1,0…0} (most-negative) : {0,1…1} (most-positive).
  - zero and neg are computed from the final sum on this same edge.
  - State → DONE.
- DONE, start=0 → IDLE. DONE, start=1 → RUN, accepting new operands back-to-back.
- start while in RUN is ignored; operands are not re-sampled.
- sum, zero, neg and ovfl change only on the final RUN edge or on reset. They are stable from done until the next final edge.
- Intermediate nibbles are written to an internal shadow register. sum is not visibly updated mid-operation.

## Timing
- Start sampled at edge t. Nibble k is written at edge t+1+k. The final nibble and saturation happen at edge t+WIDTH/4.
- done is high for the cycle after edge t+WIDTH/4. For WIDTH=16, that is 4 cycles of busy, then 1 cycle of done.
- Back-to-back throughput: one result per WIDTH/4+1 cycles.
- Reset, at any time including mid-RUN, takes effect at the next edge:
  - state=IDLE, k=0, carry=0;
  - sum=0, shadow=0;
  - zero=0, neg=0, ovfl=0;
  - busy=0, done=0.
  - Any partial operation is discarded.
- rst and start high on the same edge: rst wins.

## Structure
- Shared package `adder_serial_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - NIBBLE=4;
  - the function returning the saturation constants for a given WIDTH.
- One sub-module: a single `adder_cla_4bit` instance serves as the nibble slice. Its prop_group and gen_group outputs are left unconnected.
- Remaining logic (FSM, k counter, carry register, shadow register, saturation mux, flags) lives in one always_ff block plus small combinational glue, about 150 lines.

## Test plan
- Add, no overflow: a=0x1234, b=0x1111, sub=0 → done at cycle 5, sum=0x2345, zero=0, neg=0, ovfl=0.
- Positive saturation: a=0x7FFF, b=0x0001, sub=0 → sum=0x7FFF, ovfl=1, neg=0. Repeat with SATURATE=0 → sum=0x8000, ovfl=1, neg=1.
- Negative saturation via subtract: a=0x8000, b=0x0001, sub=1 → sum=0x8000, ovfl=1, neg=1.
- Zero result: a=0x0005, b=0x0005, sub=1 → sum=0x0000, zero=1, ovfl=0.
- Handshake:
  - Pulse start with new operands during RUN → ignored; the original result is delivered.
  - Assert start during the done cycle → next result (a=0x00F0, b=0x0010 → 0x0100) arrives 5 cycles later; no dead cycle.
- Reset mid-run: assert rst after 2 RUN cycles → next cycle all outputs 0 and state IDLE. A following start (0x0001+0x0001) yields 0x0002 with correct timing.
